// File: rtl/ddr_tx_sequencer_if.sv
// Stream handshake between fabric logic and the DDR transmit sequencer.
// The producer drives valid/data/last and the sequencer answers with ready.
interface ddr_tx_sequencer_if;
  logic       s_valid;
  logic [1:0] s_data;
  logic       s_last;
  logic       s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/ddr_tx_sequencer.sv
// Sequences one O_DDR + O_BUFT_DS output lane: OE lead-in, data burst,
// OE trail-out, release. All outputs are registered.
module ddr_tx_sequencer #(
  parameter int unsigned LEAD_CYC  = 2,
  parameter int unsigned TRAIL_CYC = 1,
  parameter int unsigned MAX_BURST = 16,
  parameter logic [1:0]  IDLE_PAT  = 2'b00
) (
  input  logic                 clk,
  input  logic                 rst,
  ddr_tx_sequencer_if.slave    s,
  output logic [1:0]           oddr_d,
  output logic                 oddr_en,
  output logic                 oddr_rst,
  output logic                 buf_oe,
  output logic                 busy,
  output logic                 err_under,
  output logic                 err_overlen,
  input  logic                 err_clr
);

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    DATA,
    TRAIL
  } state_e;

  localparam logic [7:0] MaxBeats = 8'(MAX_BURST);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [7:0] beat_q;
  logic       s_ready_q;
  logic [1:0] oddr_d_q;
  logic       oddr_en_q;
  logic       oddr_rst_q;
  logic       buf_oe_q;
  logic       busy_q;
  logic       err_under_q;
  logic       err_overlen_q;

  logic       accept;
  logic [7:0] beat_inc;
  logic       hit_max;
  logic       under_set;
  logic       over_set;

  assign accept    = s.s_valid & s_ready_q;
  assign beat_inc  = beat_q + 8'd1;
  assign hit_max   = (beat_inc == MaxBeats);
  assign under_set = (state_q == DATA) & ~s.s_valid;
  assign over_set  = accept & hit_max & ~s.s_last;

  // The first DATA cycle (ready high, data not yet on the pins) is the final
  // lead-in cycle, and the first TRAIL cycle shows the last beat; this keeps
  // buf_oe high for exactly LEAD_CYC + beats + TRAIL_CYC cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      beat_q        <= '0;
      s_ready_q     <= 1'b0;
      oddr_d_q      <= IDLE_PAT;
      oddr_en_q     <= 1'b0;
      oddr_rst_q    <= 1'b1;
      buf_oe_q      <= 1'b0;
      busy_q        <= 1'b0;
      err_under_q   <= 1'b0;
      err_overlen_q <= 1'b0;
    end else begin
      oddr_rst_q    <= 1'b0;
      err_under_q   <= under_set | (err_under_q & ~err_clr);
      err_overlen_q <= over_set | (err_overlen_q & ~err_clr);

      case (state_q)
        IDLE: begin
          oddr_d_q <= IDLE_PAT;
          if (s.s_valid) begin
            buf_oe_q  <= 1'b1;
            oddr_en_q <= 1'b1;
            busy_q    <= 1'b1;
            beat_q    <= '0;
            if (LEAD_CYC == 1) begin
              state_q   <= DATA;
              s_ready_q <= 1'b1;
            end else begin
              state_q <= LEAD;
              cnt_q   <= 4'(LEAD_CYC - 1);
            end
          end
        end

        LEAD: begin
          oddr_d_q <= IDLE_PAT;
          if (cnt_q == 4'd1) begin
            state_q   <= DATA;
            s_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        DATA: begin
          if (accept) begin
            oddr_d_q <= s.s_data;
            beat_q   <= beat_inc;
            if (s.s_last || hit_max) begin
              state_q   <= TRAIL;
              s_ready_q <= 1'b0;
              cnt_q     <= 4'(TRAIL_CYC);
            end
          end else begin
            oddr_d_q <= IDLE_PAT;
          end
        end

        TRAIL: begin
          oddr_d_q <= IDLE_PAT;
          if (cnt_q == 4'd0) begin
            state_q   <= IDLE;
            buf_oe_q  <= 1'b0;
            oddr_en_q <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b0;
          buf_oe_q  <= 1'b0;
          oddr_en_q <= 1'b0;
          busy_q    <= 1'b0;
          oddr_d_q  <= IDLE_PAT;
        end
      endcase
    end
  end

  assign s.s_ready   = s_ready_q;
  assign oddr_d      = oddr_d_q;
  assign oddr_en     = oddr_en_q;
  assign oddr_rst    = oddr_rst_q;
  assign buf_oe      = buf_oe_q;
  assign busy        = busy_q;
  assign err_under   = err_under_q;
  assign err_overlen = err_overlen_q;

endmodule

// File: tb/tb_ddr_tx_sequencer.sv
// Directed bench for ddr_tx_sequencer: a vector table for reset, nominal,
// gap and back-to-back bursts, plus hand sequences for overlength and reset.
module tb_ddr_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] oddr_d;
  logic       oddr_en;
  logic       oddr_rst;
  logic       buf_oe;
  logic       busy;
  logic       err_under;
  logic       err_overlen;
  logic       err_clr;

  int checks = 0;
  int errors = 0;

  ddr_tx_sequencer_if sif ();

  ddr_tx_sequencer #(
    .LEAD_CYC (2),
    .TRAIL_CYC(1),
    .MAX_BURST(4),
    .IDLE_PAT (2'b00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (sif),
    .oddr_d     (oddr_d),
    .oddr_en    (oddr_en),
    .oddr_rst   (oddr_rst),
    .buf_oe     (buf_oe),
    .busy       (busy),
    .err_under  (err_under),
    .err_overlen(err_overlen),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  // {buf_oe, oddr_en, oddr_rst, s_ready, oddr_d[1:0], busy, err_under, err_overlen}
  typedef struct {
    logic       rst;
    logic       valid;
    logic [1:0] data;
    logic       last;
    logic       clr;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] outs();
    return {buf_oe, oddr_en, oddr_rst, sif.s_ready, oddr_d, busy, err_under, err_overlen};
  endfunction

  task automatic add(input logic r, input logic v, input logic [1:0] d,
                     input logic l, input logic c, input logic [8:0] e);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.last = l; t.clr = c; t.exp = e;
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got oe/en/rst/rdy/d/busy/eu/eo=%b required %b", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] word(input int k);
    case (k % 3)
      0:       return 2'b11;
      1:       return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  initial begin
    int  acc;
    logic was_rdy;

    rst = 1'b0; err_clr = 1'b0;
    sif.s_valid = 1'b0; sif.s_data = 2'b00; sif.s_last = 1'b0;

    // T1 reset with s_valid high, then release
    add(0, 1, 2'b11, 0, 0, 9'b0_0_1_0_00_0_0_0);
    add(0, 1, 2'b11, 0, 0, 9'b0_0_1_0_00_0_0_0);
    add(0, 1, 2'b11, 0, 0, 9'b0_0_1_0_00_0_0_0);
    add(1, 0, 2'b00, 0, 0, 9'b0_0_0_0_00_0_0_0);
    add(1, 0, 2'b00, 0, 0, 9'b0_0_0_0_00_0_0_0);
    // T2 nominal burst 01,10,11(last)
    add(1, 1, 2'b01, 0, 0, 9'b1_1_0_0_00_1_0_0);
    add(1, 1, 2'b01, 0, 0, 9'b1_1_0_1_00_1_0_0);
    add(1, 1, 2'b01, 0, 0, 9'b1_1_0_1_01_1_0_0);
    add(1, 1, 2'b10, 0, 0, 9'b1_1_0_1_10_1_0_0);
    add(1, 1, 2'b11, 1, 0, 9'b1_1_0_0_11_1_0_0);
    add(1, 0, 2'b00, 0, 0, 9'b1_1_0_0_00_1_0_0);
    add(1, 0, 2'b00, 0, 0, 9'b0_0_0_0_00_0_0_0);
    add(1, 0, 2'b00, 0, 0, 9'b0_0_0_0_00_0_0_0);
    // T3 gap: 11, gap, 01(last), then clear
    add(1, 1, 2'b11, 0, 0, 9'b1_1_0_0_00_1_0_0);
    add(1, 1, 2'b11, 0, 0, 9'b1_1_0_1_00_1_0_0);
    add(1, 1, 2'b11, 0, 0, 9'b1_1_0_1_11_1_0_0);
    add(1, 0, 2'b00, 0, 0, 9'b1_1_0_1_00_1_1_0);
    add(1, 1, 2'b01, 1, 0, 9'b1_1_0_0_01_1_1_0);
    add(1, 0, 2'b00, 0, 0, 9'b1_1_0_0_00_1_1_0);
    add(1, 0, 2'b00, 0, 0, 9'b0_0_0_0_00_0_1_0);
    add(1, 0, 2'b00, 0, 1, 9'b0_0_0_0_00_0_0_0);
    // gap coinciding with err_clr: set wins
    add(1, 1, 2'b10, 0, 0, 9'b1_1_0_0_00_1_0_0);
    add(1, 1, 2'b10, 0, 0, 9'b1_1_0_1_00_1_0_0);
    add(1, 0, 2'b00, 0, 1, 9'b1_1_0_1_00_1_1_0);
    add(1, 1, 2'b10, 1, 0, 9'b1_1_0_0_10_1_1_0);
    add(1, 0, 2'b00, 0, 0, 9'b1_1_0_0_00_1_1_0);
    add(1, 0, 2'b00, 0, 0, 9'b0_0_0_0_00_0_1_0);
    add(1, 0, 2'b00, 0, 1, 9'b0_0_0_0_00_0_0_0);
    // T6 back-to-back with s_valid held across s_last
    add(1, 1, 2'b01, 0, 0, 9'b1_1_0_0_00_1_0_0);
    add(1, 1, 2'b01, 0, 0, 9'b1_1_0_1_00_1_0_0);
    add(1, 1, 2'b01, 1, 0, 9'b1_1_0_0_01_1_0_0);
    add(1, 1, 2'b10, 0, 0, 9'b1_1_0_0_00_1_0_0);
    add(1, 1, 2'b10, 0, 0, 9'b0_0_0_0_00_0_0_0);
    add(1, 1, 2'b10, 0, 0, 9'b1_1_0_0_00_1_0_0);
    add(1, 1, 2'b10, 0, 0, 9'b1_1_0_1_00_1_0_0);
    add(1, 1, 2'b10, 1, 0, 9'b1_1_0_0_10_1_0_0);
    add(1, 0, 2'b00, 0, 0, 9'b1_1_0_0_00_1_0_0);
    add(1, 0, 2'b00, 0, 0, 9'b0_0_0_0_00_0_0_0);

    foreach (vecs[i]) begin
      rst         = vecs[i].rst;
      sif.s_valid = vecs[i].valid;
      sif.s_data  = vecs[i].data;
      sif.s_last  = vecs[i].last;
      err_clr     = vecs[i].clr;
      tick();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
    err_clr = 1'b0;

    // T4 overlength: six words offered without s_last, MAX_BURST=4
    sif.s_valid = 1'b1; sif.s_last = 1'b0; sif.s_data = word(0);
    tick();
    tick();
    check("T4 data entry", outs(), 9'b1_1_0_1_00_1_0_0);
    acc = 0;
    for (int k = 0; k < 10 && acc < 4; k++) begin
      sif.s_data = word(acc);
      was_rdy = sif.s_ready;
      tick();
      if (was_rdy) acc++;
    end
    check("T4 after 4th beat", outs(), 9'b1_1_0_0_11_1_0_1);
    for (int k = 0; k < 2; k++) begin
      sif.s_data = word(acc);
      was_rdy = sif.s_ready;
      tick();
      if (was_rdy) acc++;
    end
    check_int("T4 accepted", acc, 4);
    sif.s_valid = 1'b0;
    tick();
    check("T4 idle sticky", outs(), 9'b0_0_0_0_00_0_0_1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("T4 clear", outs(), 9'b0_0_0_0_00_0_0_0);

    // T5 reset after the second beat, then a full new burst
    sif.s_valid = 1'b1; sif.s_data = 2'b10; sif.s_last = 1'b0;
    tick();
    tick();
    tick();
    sif.s_data = 2'b01;
    tick();
    check("T5 beat2", outs(), 9'b1_1_0_1_01_1_0_0);
    rst = 1'b0;
    tick();
    check("T5 reset edge", outs(), 9'b0_0_1_0_00_0_0_0);
    rst = 1'b1; sif.s_valid = 1'b0;
    tick();
    check("T5 released", outs(), 9'b0_0_0_0_00_0_0_0);
    sif.s_valid = 1'b1; sif.s_data = 2'b11;
    tick();
    check("T5 lead1", outs(), 9'b1_1_0_0_00_1_0_0);
    tick();
    check("T5 lead2", outs(), 9'b1_1_0_1_00_1_0_0);
    sif.s_last = 1'b1;
    tick();
    check("T5 beat", outs(), 9'b1_1_0_0_11_1_0_0);
    sif.s_valid = 1'b0; sif.s_last = 1'b0;
    tick();
    check("T5 trail", outs(), 9'b1_1_0_0_00_1_0_0);
    tick();
    check("T5 idle", outs(), 9'b0_0_0_0_00_0_0_0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
